// File: rtl/load_store_unit_if.sv
// Request/response handshake between the core pipeline and the load/store unit.
// The core drives requests as master; the unit answers as slave.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_fault;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_fault
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_data, resp_fault
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit driving the byte-lane BRAM; range-checks
// requests, waits out the one-cycle read latency and extends load data.
module load_store_unit #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_1FFF
) (
    input  logic               clk,
    input  logic               reset,
    load_store_unit_if.slave   bus,
    output logic [31:0]        memory_address,
    output logic [31:0]        memory_in,
    output logic [1:0]         memory_size,
    output logic               memory_write_enable,
    input  logic [31:0]        memory_out
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    logic [1:0]  state;
    logic        write_q;
    logic [1:0]  size_q;
    logic        signed_q;

    logic [2:0]  nbytes;
    logic [32:0] last_byte;
    logic        req_fault;
    logic [31:0] wdata_masked;
    logic [31:0] load_ext;

    always_comb begin
        nbytes       = 3'd4;
        wdata_masked = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                nbytes       = 3'd1;
                wdata_masked = {24'h0, bus.req_wdata[7:0]};
            end
            2'b01: begin
                nbytes       = 3'd2;
                wdata_masked = {16'h0, bus.req_wdata[15:0]};
            end
            default: ;
        endcase
        // 33-bit sum so a request wrapping past 0xFFFF_FFFF still faults
        last_byte = {1'b0, bus.req_addr} + {30'h0, nbytes} - 33'd1;
        req_fault = (bus.req_size == 2'b11) || (last_byte > {1'b0, ADDR_LIMIT});
    end

    always_comb begin
        case (size_q)
            2'b00:   load_ext = {{24{signed_q & memory_out[7]}}, memory_out[7:0]};
            2'b01:   load_ext = {{16{signed_q & memory_out[15]}}, memory_out[15:0]};
            default: load_ext = memory_out;
        endcase
    end

    assign bus.req_ready       = (state == IDLE);
    assign bus.resp_valid      = (state == RESP);
    assign memory_write_enable = (state == ACCESS) && write_q && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            write_q        <= 1'b0;
            size_q         <= 2'b00;
            signed_q       <= 1'b0;
            bus.resp_data  <= '0;
            bus.resp_fault <= 1'b0;
            memory_address <= '0;
            memory_in      <= '0;
            memory_size    <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        write_q        <= bus.req_write;
                        size_q         <= bus.req_size;
                        signed_q       <= bus.req_signed;
                        bus.resp_data  <= '0;
                        bus.resp_fault <= req_fault;
                        if (req_fault) begin
                            state <= RESP;
                        end else begin
                            memory_address <= bus.req_addr;
                            memory_size    <= bus.req_size;
                            memory_in      <= wdata_masked;
                            state          <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    state <= write_q ? RESP : CAPTURE;
                end
                CAPTURE: begin
                    bus.resp_data <= load_ext;
                    state         <= RESP;
                end
                default: begin
                    if (bus.resp_ready) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a byte-array BRAM model that has
// one-cycle read latency and little-endian lane order from the current address.
module tb_load_store_unit;

    typedef struct {
        logic [31:0] data;
        logic        fault;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] memory_address;
    logic [31:0] memory_in;
    logic [1:0]  memory_size;
    logic        memory_write_enable;
    logic [31:0] memory_out;

    load_store_unit_if bus ();

    load_store_unit #(.ADDR_LIMIT(32'h0000_1FFF)) dut (
        .clk                 (clk),
        .reset               (reset),
        .bus                 (bus),
        .memory_address      (memory_address),
        .memory_in           (memory_in),
        .memory_size         (memory_size),
        .memory_write_enable (memory_write_enable),
        .memory_out          (memory_out)
    );

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          we_count = 0;
    logic [31:0] last_win = '0;
    logic        seen = 1'b0;
    exp_t        sb[$];
    logic [7:0]  mem [0:8191];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        logic [12:0] a;
        for (int i = 0; i < 8192; i++) mem[i] = 8'(i) ^ 8'h5A;
        memory_out <= '0;
        forever begin
            @(posedge clk);
            a = memory_address[12:0];
            memory_out <= {mem[a + 13'd3], mem[a + 13'd2], mem[a + 13'd1], mem[a]};
            if (memory_write_enable) begin
                mem[a] = memory_in[7:0];
                if (memory_size != 2'b00) mem[a + 13'd1] = memory_in[15:8];
                if (memory_size == 2'b10) begin
                    mem[a + 13'd2] = memory_in[23:16];
                    mem[a + 13'd3] = memory_in[31:24];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (memory_write_enable) begin
                we_count++;
                last_win = memory_in;
            end
            if (bus.resp_valid && !seen) begin
                seen = 1'b1;
                check("sb_depth", 32'(sb.size()), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("resp_data", bus.resp_data, e.data);
                    check("resp_fault", {31'h0, bus.resp_fault}, {31'h0, e.fault});
                    check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                end
            end else if (!bus.resp_valid) begin
                seen = 1'b0;
            end
        end
    end

    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] ed, input logic ef);
        exp_t e;
        logic ok;
        @(posedge clk); #1;
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("req_accept", {31'h0, ok}, 32'd1);
        e.data  = ed;
        e.fault = ef;
        e.lat   = ef ? 1 : (w ? 2 : 3);
        e.acc   = cyc + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check("resp_wait", {31'h0, done}, 32'd1);
    endtask

    task automatic run(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] ed, input logic ef);
        issue(w, sz, sg, a, wd, ed, ef);
        wait_done();
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", {31'h0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'd0);
        check("rst_resp_data", bus.resp_data, 32'd0);
        check("rst_resp_fault", {31'h0, bus.resp_fault}, 32'd0);
        check("rst_mem_addr", memory_address, 32'd0);
        check("rst_mem_in", memory_in, 32'd0);
        check("rst_mem_size", {30'h0, memory_size}, 32'd0);
        check("rst_mem_we", {31'h0, memory_write_enable}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int w0;
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs();

        // word store then load
        w0 = we_count;
        run(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        check("we_pulses_word", 32'(we_count - w0), 32'd1);
        check("win_word", last_win, 32'hDEADBEEF);
        run(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        check("we_pulses_load", 32'(we_count - w0), 32'd1);

        // word-crossing half store
        run(1'b1, 2'b01, 1'b0, 32'h3, 32'h12348001, 32'h0, 1'b0);
        check("win_half", last_win, 32'h00008001);
        run(1'b0, 2'b01, 1'b1, 32'h3, 32'h0, 32'hFFFF8001, 1'b0);
        run(1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 32'h00008001, 1'b0);
        run(1'b0, 2'b00, 1'b0, 32'h4, 32'h0, 32'h00000080, 1'b0);

        // byte store, neighbour untouched
        run(1'b1, 2'b00, 1'b0, 32'h7, 32'hAAAAAA80, 32'h0, 1'b0);
        check("win_byte", last_win, 32'h00000080);
        run(1'b0, 2'b00, 1'b1, 32'h7, 32'h0, 32'hFFFFFF80, 1'b0);
        run(1'b0, 2'b00, 1'b0, 32'h7, 32'h0, 32'h00000080, 1'b0);
        run(1'b0, 2'b00, 1'b0, 32'h6, 32'h0, 32'h0000005C, 1'b0);

        // faults leave memory ports alone and never write
        w0 = we_count;
        run(1'b0, 2'b10, 1'b0, 32'h1FFE, 32'h0, 32'h0, 1'b1);
        check("fault_addr_held", memory_address, 32'h6);
        run(1'b1, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h55555555, 32'h0, 1'b1);
        run(1'b0, 2'b11, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1);
        run(1'b1, 2'b11, 1'b0, 32'h40, 32'h77777777, 32'h0, 1'b1);
        run(1'b1, 2'b01, 1'b0, 32'h1FFF, 32'h1234, 32'h0, 1'b1);
        check("fault_no_we", 32'(we_count - w0), 32'd0);
        run(1'b0, 2'b00, 1'b0, 32'h1FFF, 32'h0, 32'h000000A5, 1'b0);
        run(1'b1, 2'b10, 1'b0, 32'h1FFC, 32'h11223344, 32'h0, 1'b0);
        run(1'b0, 2'b10, 1'b0, 32'h1FFC, 32'h0, 32'h11223344, 1'b0);

        // back-pressure on the response
        bus.resp_ready = 1'b0;
        w0 = we_count;
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        wait_done();
        bus.req_write = 1'b1;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h10;
        bus.req_wdata = 32'h0BADF00D;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_resp_valid", {31'h0, bus.resp_valid}, 32'd1);
            check("hold_resp_data", bus.resp_data, 32'hDEADBEEF);
            check("hold_mem_addr", memory_address, 32'h10);
            check("hold_req_ready", {31'h0, bus.req_ready}, 32'd0);
        end
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("release_resp_valid", {31'h0, bus.resp_valid}, 32'd0);
        check("release_req_ready", {31'h0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        check("hold_no_we", 32'(we_count - w0), 32'd0);
        run(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // reset during ACCESS of a store suppresses the write
        w0 = we_count;
        @(posedge clk); #1;
        bus.req_write = 1'b1;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'hCAFEF00D;
        bus.req_valid = 1'b1;
        @(negedge clk);
        check("rst_mid_accept", {31'h0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_addr", memory_address, 32'h20);
        check("rst_mid_we", {31'h0, memory_write_enable}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        check("rst_mid_no_we", 32'(we_count - w0), 32'd0);
        run(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h79787B7A, 1'b0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits directly upstream of the byte-lane BRAM memory block and is its only driver. Accepts one load or store request at a time from the core pipeline over a valid/ready handshake, range-checks the request, and drives the memory address/data/size/write-enable ports. It waits out the one-cycle BRAM read latency while holding the address stable, because the memory's output lane rotation depends on the current address offset. It then returns sign- or zero-extended load data, or a store acknowledge, over a second valid/ready handshake.

Parameters:
ADDR_LIMIT, 32'h0000_1FFF, highest legal byte address (4 lanes x 2048 bytes).

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  in  32  byte address, any alignment
req_wdata  in  32  store data, low-order bytes used
resp_valid  out  1  response present
resp_ready  in  1  consumer takes response
resp_data  out  32  extended load data; 0 for stores and faults
resp_fault  out  1  request rejected, no memory write performed
memory_address  out  32  to memory block
memory_in  out  32  to memory block
memory_size  out  2  to memory block
memory_write_enable  out  1  to memory block

Behaviour:
- Reset and idle values:
  - Reset is synchronous and active-high on clk.
  - Reset drives state IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_fault=0, memory_address=0, memory_in=0, memory_size=00, memory_write_enable=0.
- States: IDLE, ACCESS, CAPTURE, RESP.
- IDLE:
  - req_ready=1; req_ready is 0 in every other state.
  - On req_valid, all request fields are latched at that edge.
  - Fault check:
    - size 11 is a fault.
    - Otherwise nbytes = 1, 2 or 4, and the request faults if (33-bit) req_addr + nbytes - 1 > ADDR_LIMIT. This covers wrap at 0xFFFF_FFFF.
  - Fault -> RESP with resp_fault=1 and resp_data=0. The memory ports are not updated.
  - No fault -> ACCESS. At the same edge:
    - memory_address <= req_addr; memory_size <= req_size.
    - memory_in <= req_wdata masked to size, upper bytes zeroed.
- ACCESS:
  - One cycle; the BRAM samples at its end.
  - memory_write_enable = latched write flag AND NOT reset, gated combinationally, so no write occurs in any cycle where reset is high.
  - Store -> RESP with resp_data=0 and resp_fault=0.
  - Load -> CAPTURE.
- CAPTURE:
  - One cycle. memory_address and memory_size are held unchanged; memory_write_enable=0.
  - At the end of the cycle, resp_data <= extension of memory_out:
    - byte: bits [7:0], bit 7 replicated if signed, else zero.
    - half: bits [15:0], bit 15 replicated if signed, else zero.
    - word: passthrough; req_signed is ignored.
  - Next state RESP.
- RESP:
  - resp_valid=1; resp_data and resp_fault are stable until handshake.
  - On resp_ready -> IDLE; resp_valid drops the next cycle.
  - memory_address and memory_size stay held.
- Latency, counted as cycles after the accept edge until resp_valid is high: load 3, store 2, fault 1.
- Throughput: one request in flight. A new request is accepted no earlier than the cycle after the response handshake.
- memory_write_enable is high for exactly one cycle per non-faulting store and never for loads or faults.
- Unaligned and word-crossing accesses are passed through unchanged; the memory block handles lane splitting.
- Reset mid-operation: from any state, the next state is IDLE, any pending response is discarded, and no memory write occurs in the reset cycle.
- req_signed on stores and req_wdata on loads are don't-care.

Test Plan:
- Store word 0xDEADBEEF at 0x10, then load word at 0x10 -> store response 2 cycles after accept with fault=0; load resp_data=0xDEADBEEF 3 cycles after accept; exactly one write-enable pulse.
- Store half 0x8001 at 0x3 (crosses a word), then load half signed at 0x3 -> 0xFFFF8001; unsigned -> 0x00008001; byte at 0x4 unsigned -> 0x00000080.
- Store byte 0x80 at 0x7, then load byte signed -> 0xFFFFFF80; unsigned -> 0x00000080; the byte at 0x6 is unchanged.
- Word load at 0x1FFE, word store at 0xFFFF_FFFF, and any request with size 11 -> resp_fault=1, resp_data=0 one cycle after accept; memory_write_enable never asserts; a word at 0x1FFC succeeds.
- Hold resp_ready=0 for 5 cycles after a load response -> resp_valid, resp_data and memory_address stay constant; req_ready=0 and req_valid is ignored; release -> IDLE the next cycle.
- Assert reset for one cycle during ACCESS of a store to 0x20 -> memory_write_enable stays 0; a subsequent load of 0x20 returns the old value; all outputs are at reset values the cycle after.
